byte_serial_tx: RTL and testbench

//   Parallel-to-serial transmitter for the 8-bit register datapath.

---
 rtl/byte_serial_tx.sv | 122 ++++++++++++
 tb/tb_byte_serial_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/byte_serial_tx.sv
// Parallel-to-serial transmitter: one byte per valid/ready handshake, sent LSB-first
// framed as start bit (0), DATA_W data bits, stop bit (1), each bit held CLKS_PER_BIT cycles.
module byte_serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_last_c;

  assign cnt_last_c = (cnt_q == CNT_LAST);

  // Next-state logic; outputs are derived from the next state so they land in flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          state_d = ST_START;
          shreg_d = data_in;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_last_c) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_last_c) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_last_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    tx_d    = 1'b1;
    if (state_d == ST_START) tx_d = 1'b0;
    if (state_d == ST_DATA)  tx_d = shreg_d[0];
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_out = ready_q;
  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Bench for byte_serial_tx: a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance, frames
// checked cycle by cycle against expected frame words queued when each byte is driven.
module tb_byte_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in4, data_in1;
  logic       valid_in4, valid_in1;
  logic       ready4, tx4, busy4, done4;
  logic       ready1, tx1, busy1, done1;

  int errors = 0;
  int checks = 0;

  // expected frame words, bit i = i-th bit on the line (start, d0..d7, stop)
  logic [9:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         hold;
    bit         chg;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  byte_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in4), .valid_in(valid_in4),
    .ready_out(ready4), .tx_out(tx4), .busy(busy4), .done(done4)
  );

  byte_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in1), .valid_in(valid_in1),
    .ready_out(ready1), .tx_out(tx1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {tx,done,busy,ready}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs(input bit sel);
    return sel ? {tx1, done1, busy1, ready1} : {tx4, done4, busy4, ready4};
  endfunction

  // Called right after the accepting edge; checks n cycles of the frame, plus the
  // following idle cycle if the whole frame was checked.
  task automatic check_frame(input bit sel, input bit hold, input bit chg, input int n);
    logic [9:0] f;
    int cpb;
    int total;
    cpb   = sel ? 1 : 4;
    total = 10 * cpb;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got 0 queued frames expected 1");
      return;
    end
    f = sb.pop_front();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("frame%0d_cyc%0d", sel ? 1 : 4, i + 1), obs(sel),
            {f[i / cpb], (i == total - 1), 1'b1, 1'b0});
      if (i == 0 && !hold) begin
        if (sel) valid_in1 = 1'b0;
        else     valid_in4 = 1'b0;
      end
      if (chg && i == 1) data_in4 = 8'h00;
    end
    if (n == total) begin
      @(negedge clk);
      check("idle_after_frame", obs(sel), 4'b1001);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, hold: 1'b0, chg: 1'b0};
    vecs[1] = '{data: 8'h01, frame: 10'b1000000010, hold: 1'b1, chg: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, hold: 1'b0, chg: 1'b0};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000, hold: 1'b0, chg: 1'b1};

    rst = 1'b1;
    data_in4 = 8'h00; valid_in4 = 1'b0;
    data_in1 = 8'h00; valid_in1 = 1'b0;
    repeat (2) @(negedge clk);
    check("por_reset4", obs(1'b0), 4'b1001);
    check("por_reset1", obs(1'b1), 4'b1001);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle4", obs(1'b0), 4'b1001);

    // mid-idle reset held 3 cycles with valid high: reset wins
    rst = 1'b1; valid_in4 = 1'b1; data_in4 = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_reset_cyc%0d", i), obs(1'b0), 4'b1001);
    end
    rst = 1'b0; valid_in4 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("no_accept_under_reset", obs(1'b0), 4'b1001);
    end

    // table-driven frames on the 4-cycles-per-bit instance
    for (int v = 0; v < 4; v++) begin
      data_in4 = vecs[v].data;
      valid_in4 = 1'b1;
      sb.push_back(vecs[v].frame);
      @(posedge clk);
      check_frame(1'b0, vecs[v].hold, vecs[v].chg, 40);
    end

    // reset during data bit 3 of 0xF0 abandons the frame with no done pulse
    data_in4 = 8'hF0; valid_in4 = 1'b1;
    sb.push_back(10'b1111100000);
    @(posedge clk);
    check_frame(1'b0, 1'b0, 1'b0, 18);
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset", obs(1'b0), 4'b1001);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", obs(1'b0), 4'b1001);
    end
    data_in4 = 8'h55; valid_in4 = 1'b1;
    sb.push_back(10'b1010101010);
    @(posedge clk);
    check_frame(1'b0, 1'b0, 1'b0, 40);

    // one cycle per bit
    @(negedge clk);
    data_in1 = 8'h80; valid_in1 = 1'b1;
    sb.push_back(10'b1100000000);
    @(posedge clk);
    check_frame(1'b1, 1'b0, 1'b0, 10);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d queued frames expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
